// File: rtl/mul_pkg.sv
// Shared definitions for the shift-and-add multiplier: default widths and
// the controller state encoding.
package mul_pkg;

  localparam int W_DEF     = 8;
  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_DONE    = 2'd2,
    S_ILLEGAL = 2'd3
  } state_e;

endpackage

// File: rtl/ripple_adder_2w.sv
// Ripple-carry adder built from full_adder cells; the only arithmetic
// used by the shift-and-add multiplier controller.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

module ripple_adder_2w #(
  parameter int W2 = 16
) (
  input  logic [W2-1:0] a,
  input  logic [W2-1:0] b,
  input  logic          c_in,
  output logic [W2-1:0] s,
  output logic          c_out
);

  logic [W2:0] carry;

  assign carry[0] = c_in;
  assign c_out    = carry[W2];

  for (genvar i = 0; i < W2; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .c_in (carry[i]),
      .s    (s[i]),
      .c_out(carry[i+1])
    );
  end

endmodule

// File: rtl/shift_add_mul_ctrl.sv
// Multi-cycle unsigned W x W multiplier: an FSM walks the multiplier bits,
// reusing one 2W-bit ripple adder for every partial-product accumulation.
module shift_add_mul_ctrl
  import mul_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p,
  output logic           busy
);

  state_e           state_q, state_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [2*W-1:0]   mcand_q, mcand_d;
  logic [W-1:0]     mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]   p_q, p_d;
  logic             out_valid_q, out_valid_d;

  logic [2*W-1:0]   add_sum;
  logic             add_cout;

  ripple_adder_2w #(
    .W2(2*W)
  ) u_adder (
    .a    (acc_q),
    .b    (mcand_q),
    .c_in (1'b0),
    .s    (add_sum),
    .c_out(add_cout)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    p_d         = p_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mcand_d  = {{W{1'b0}}, a};
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (mplier_q[0]) begin
          acc_d = add_sum;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(W - 1)) begin
          state_d = S_DONE;
        end
      end
      // First DONE cycle registers the product; the handshake runs after that.
      S_DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          p_d         = acc_q;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          p_d         = '0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        p_d         = '0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
    end
  end

  // A full product always fits in 2W bits, so the adder must never carry out.
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_RUN) begin
      assert (!add_cout);
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign out_valid = out_valid_q;
  assign p         = p_q;

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// Directed self-checking bench for shift_add_mul_ctrl: latency, handshake,
// reset-abort and back-to-back random products against a*b.
module tb_shift_add_mul_ctrl;
  import mul_pkg::*;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] p;
  logic           busy;

  int pass_count  = 0;
  int check_count = 0;
  bit cout_seen   = 1'b0;

  shift_add_mul_ctrl #(.W(W), .CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .p        (p),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && dut.state_q == S_RUN && dut.add_cout === 1'b1) cout_seen = 1'b1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic waitForValid(output int n);
    n = 0;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
  endtask

  task automatic runOp(input string tag, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic [31:0] expected);
    int n;
    applyStimulus(av, bv);
    waitForValid(n);
    checkOutput({tag, " latency"}, n, 9);
    checkOutput({tag, " product"}, p, expected);
    tick();
  endtask

  initial begin
    int   n;
    bit   flag;
    int   bad_p, bad_iv, valid_seen;
    logic [W-1:0]   ra, rb;
    logic [2*W-1:0] exp_p;

    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    tick();
    tick();
    checkOutput("reset in_ready", in_ready, 0);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset p", p, 0);
    checkOutput("reset busy", busy, 0);
    rst = 1'b0;
    #1;
    checkOutput("idle in_ready", in_ready, 1);

    // 13 * 11 with exact latency, then back to IDLE
    runOp("13x11", 8'd13, 8'd11, 143);
    checkOutput("13x11 idle in_ready", in_ready, 1);
    checkOutput("13x11 idle p", p, 0);
    checkOutput("13x11 idle out_valid", out_valid, 0);

    runOp("255x255", 8'd255, 8'd255, 65025);
    runOp("0x200", 8'd0, 8'd200, 0);
    runOp("200x0", 8'd200, 8'd0, 0);

    // 7 * 6 with a stray 3 * 3 request offered throughout RUN and DONE
    applyStimulus(8'd7, 8'd6);
    flag = 1'b0;
    n    = 0;
    while (!out_valid && n < 30) begin
      in_valid = 1'b1;
      a        = 8'd3;
      b        = 8'd3;
      if (in_ready) flag = 1'b1;
      tick();
      n++;
    end
    checkOutput("7x6 latency", n, 9);
    checkOutput("7x6 in_ready low in run", flag, 0);
    checkOutput("7x6 in_ready low in done", in_ready, 0);
    checkOutput("7x6 product", p, 42);
    tick();
    in_valid = 1'b0;
    checkOutput("7x6 no accept on done exit", busy, 0);
    checkOutput("7x6 back to idle", in_ready, 1);

    // 100 * 2 held in DONE by a stalled consumer
    out_ready = 1'b0;
    applyStimulus(8'd100, 8'd2);
    waitForValid(n);
    checkOutput("100x2 latency", n, 9);
    flag = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid !== 1'b1 || p !== 16'd200) flag = 1'b1;
    end
    checkOutput("100x2 stall stable", flag, 0);
    checkOutput("100x2 product", p, 200);
    out_ready = 1'b1;
    tick();
    checkOutput("100x2 released p", p, 0);
    checkOutput("100x2 released out_valid", out_valid, 0);
    checkOutput("100x2 released in_ready", in_ready, 1);

    // Reset on the 4th RUN edge of 9 * 9 discards the operation
    applyStimulus(8'd9, 8'd9);
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    checkOutput("abort in_ready during rst", in_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("abort busy", busy, 0);
    checkOutput("abort out_valid", out_valid, 0);
    checkOutput("abort p", p, 0);
    checkOutput("abort in_ready", in_ready, 1);
    runOp("5x5 after abort", 8'd5, 8'd5, 25);

    // Back-to-back random operands with both handshakes held high
    bad_p      = 0;
    bad_iv     = 0;
    valid_seen = 0;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      ra    = W'($urandom_range(0, 255));
      rb    = W'($urandom_range(0, 255));
      exp_p = 16'(ra) * 16'(rb);
      a     = ra;
      b     = rb;
      if (!in_ready) bad_iv++;
      tick();
      a = ~ra;
      b = ~rb;
      n = 0;
      while (!in_ready && n < 40) begin
        if (out_valid) begin
          valid_seen++;
          if (p !== exp_p) bad_p++;
        end
        tick();
        n++;
      end
      if (n + 1 != 11) bad_iv++;
    end
    in_valid = 1'b0;
    checkOutput("b2b product mismatches", bad_p, 0);
    checkOutput("b2b interval errors", bad_iv, 0);
    checkOutput("b2b valid cycles", valid_seen, 1000);
    checkOutput("adder carry-out seen", cout_seen, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
